// File: rtl/crossing_sequencer_pkg.sv
// crossing_sequencer_pkg: shared state codes, bank constants and start-time helpers
package crossing_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_CROSS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_LOSE  = 3'd5;

    localparam logic [1:0] GS_FAIL    = 2'd0;
    localparam logic [1:0] GS_SUCCESS = 2'd1;
    localparam logic [1:0] GS_PLAYING = 2'd2;
    localparam logic [1:0] GS_IDLE    = 2'd3;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int T_EASY_DEF = 60;
    localparam int T_MED_DEF  = 40;
    localparam int T_HARD_DEF = 20;

    typedef enum logic [1:0] {P_NONE, P_CAT, P_DOG, P_MOUSE} pick_t;

    // seconds (0..99) to packed {tens, ones} BCD
    function automatic logic [7:0] to_bcd(input int t);
        logic [3:0] tn;
        logic [3:0] on;
        tn = 4'(t / 10);
        on = 4'(t % 10);
        return {tn, on};
    endfunction

    function automatic logic [1:0] state_code(input logic [2:0] s);
        return (s == S_WIN)  ? GS_SUCCESS :
               (s == S_LOSE) ? GS_FAIL :
               (s == S_IDLE) ? GS_IDLE : GS_PLAYING;
    endfunction

endpackage

// File: rtl/crossing_sequencer_if.sv
// crossing_sequencer_if: control inputs and display-facing outputs of the game sequencer
interface crossing_sequencer_if;
    logic       tick_4Hz;
    logic       tick_1Hz;
    logic       start;
    logic [1:0] difficulty;
    logic       sel_cat;
    logic       sel_dog;
    logic       sel_mouse;
    logic       go;
    logic       cat_position;
    logic       dog_position;
    logic       mouse_position;
    logic       canoe_position;
    logic       cat_crossing;
    logic       dog_crossing;
    logic       mouse_crossing;
    logic       canoe_crossing;
    logic [3:0] cnt_canoe;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [1:0] game_state;

    modport master (
        output tick_4Hz, tick_1Hz, start, difficulty, sel_cat, sel_dog, sel_mouse, go,
        input  cat_position, dog_position, mouse_position, canoe_position,
               cat_crossing, dog_crossing, mouse_crossing, canoe_crossing,
               cnt_canoe, ones, tens, game_state
    );

    modport slave (
        input  tick_4Hz, tick_1Hz, start, difficulty, sel_cat, sel_dog, sel_mouse, go,
        output cat_position, dog_position, mouse_position, canoe_position,
               cat_crossing, dog_crossing, mouse_crossing, canoe_crossing,
               cnt_canoe, ones, tens, game_state
    );
endinterface

// File: rtl/crossing_sequencer_bcd_countdown.sv
// bcd_countdown: two-digit BCD down counter that saturates at 00
module bcd_countdown (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic       en,
    input  logic       tick,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       zero
);
    assign zero = (ones == 4'd0) && (tens == 4'd0);

    // load wins over counting; ones borrows from tens, and 00 holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (load) begin
            ones <= load_ones;
            tens <= load_tens;
        end else if (en && tick && !zero) begin
            ones <= (ones == 4'd0) ? 4'd9 : ones - 4'd1;
            tens <= (ones == 4'd0) ? tens - 4'd1 : tens;
        end
    end
endmodule

// File: rtl/crossing_sequencer.sv
// crossing_sequencer: river-crossing game FSM owning piece positions, canoe animation and timer
module crossing_sequencer
    import crossing_sequencer_pkg::*;
#(
    parameter int CROSS_STEPS = 8,
    parameter int T_EASY      = T_EASY_DEF,
    parameter int T_MED       = T_MED_DEF,
    parameter int T_HARD      = T_HARD_DEF
) (
    input logic                 clk_1kHz,
    input logic                 rst,
    crossing_sequencer_if.slave bus
);
    localparam logic [7:0] BCD_EASY = to_bcd(T_EASY);
    localparam logic [7:0] BCD_MED  = to_bcd(T_MED);
    localparam logic [7:0] BCD_HARD = to_bcd(T_HARD);
    localparam logic [3:0] LAST_STEP = 4'(CROSS_STEPS - 1);

    logic [2:0] state, state_n;
    logic [1:0] gs;
    logic       cat_pos, dog_pos, mouse_pos, canoe_pos;
    logic       cat_x, dog_x, mouse_x, canoe_x;
    logic [3:0] cnt;
    pick_t      pick;
    logic       any_sel, pick_here, unsafe, win, active, last_tick, zero, load;
    logic [7:0] load_val;

    // passenger choice, bank safety and the next FSM state
    always_comb begin
        pick      = bus.sel_cat ? P_CAT : bus.sel_dog ? P_DOG : bus.sel_mouse ? P_MOUSE : P_NONE;
        any_sel   = (pick != P_NONE);
        pick_here = (pick == P_CAT)   ? (cat_pos == canoe_pos) :
                    (pick == P_DOG)   ? (dog_pos == canoe_pos) :
                    (pick == P_MOUSE) ? (mouse_pos == canoe_pos) : 1'b0;
        unsafe    = (cat_pos != canoe_pos) && ((dog_pos == cat_pos) || (mouse_pos == cat_pos));
        win       = (cat_pos == RIGHT) && (dog_pos == RIGHT) && (mouse_pos == RIGHT) && (canoe_pos == RIGHT);
        active    = (state == S_PLAY) || (state == S_CROSS) || (state == S_CHECK);
        last_tick = bus.tick_4Hz && (cnt == LAST_STEP);
        state_n   = state;
        if (!bus.start)
            state_n = S_IDLE;
        else if (state == S_IDLE)
            state_n = S_PLAY;
        else if (state == S_PLAY)
            state_n = zero ? S_LOSE : (bus.go && !any_sel) ? S_CROSS : S_PLAY;
        else if (state == S_CROSS)
            state_n = zero ? S_LOSE : last_tick ? S_CHECK : S_CROSS;
        else if (state == S_CHECK)
            state_n = unsafe ? S_LOSE : win ? S_WIN : zero ? S_LOSE : S_PLAY;
    end

    assign load     = (state == S_IDLE) && (state_n == S_PLAY);
    assign load_val = (bus.difficulty == 2'd0) ? BCD_EASY :
                      (bus.difficulty == 2'd1) ? BCD_MED : BCD_HARD;

    bcd_countdown u_timer (
        .clk       (clk_1kHz),
        .rst       (rst),
        .load      (load),
        .load_ones (load_val[3:0]),
        .load_tens (load_val[7:4]),
        .en        (active && bus.start),
        .tick      (bus.tick_1Hz),
        .ones      (bus.ones),
        .tens      (bus.tens),
        .zero      (zero)
    );

    // pieces only move on legal transitions so a terminal or idle state freezes them
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gs        <= GS_IDLE;
            cat_pos   <= LEFT;
            dog_pos   <= LEFT;
            mouse_pos <= LEFT;
            canoe_pos <= LEFT;
            cat_x     <= 1'b0;
            dog_x     <= 1'b0;
            mouse_x   <= 1'b0;
            canoe_x   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            state <= state_n;
            gs    <= state_code(state_n);
            if (load) begin
                cat_pos   <= LEFT;
                dog_pos   <= LEFT;
                mouse_pos <= LEFT;
                canoe_pos <= LEFT;
                cat_x     <= 1'b0;
                dog_x     <= 1'b0;
                mouse_x   <= 1'b0;
                canoe_x   <= 1'b0;
                cnt       <= 4'd0;
            end else if (state == S_PLAY && state_n == S_PLAY && pick_here) begin
                cat_x   <= (pick == P_CAT) && !cat_x;
                dog_x   <= (pick == P_DOG) && !dog_x;
                mouse_x <= (pick == P_MOUSE) && !mouse_x;
            end else if (state == S_PLAY && state_n == S_CROSS) begin
                canoe_x <= 1'b1;
                cnt     <= 4'd0;
            end else if (state == S_CROSS && state_n == S_CHECK) begin
                canoe_pos <= ~canoe_pos;
                cat_pos   <= cat_pos ^ cat_x;
                dog_pos   <= dog_pos ^ dog_x;
                mouse_pos <= mouse_pos ^ mouse_x;
                cat_x     <= 1'b0;
                dog_x     <= 1'b0;
                mouse_x   <= 1'b0;
                canoe_x   <= 1'b0;
                cnt       <= 4'd0;
            end else if (state == S_CROSS && state_n == S_CROSS && bus.tick_4Hz) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign bus.cat_position   = cat_pos;
    assign bus.dog_position   = dog_pos;
    assign bus.mouse_position = mouse_pos;
    assign bus.canoe_position = canoe_pos;
    assign bus.cat_crossing   = cat_x;
    assign bus.dog_crossing   = dog_x;
    assign bus.mouse_crossing = mouse_x;
    assign bus.canoe_crossing = canoe_x;
    assign bus.cnt_canoe      = cnt;
    assign bus.game_state     = gs;
endmodule

// File: tb/tb_crossing_sequencer.sv
// tb_crossing_sequencer: directed self-checking bench for the river-crossing game FSM
module tb_crossing_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    crossing_sequencer_if bus ();

    crossing_sequencer dut (
        .clk_1kHz (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick4();
        bus.tick_4Hz = 1'b1;
        cyc();
        bus.tick_4Hz = 1'b0;
        cyc();
    endtask

    task automatic tick1();
        bus.tick_1Hz = 1'b1;
        cyc();
        bus.tick_1Hz = 1'b0;
        cyc();
    endtask

    // board optional passenger, depart, run 8 animation ticks, then let CHECK resolve
    task automatic do_cross(input logic c, input logic d, input logic m);
        if (c || d || m) begin
            bus.sel_cat = c;
            bus.sel_dog = d;
            bus.sel_mouse = m;
            cyc();
            bus.sel_cat = 1'b0;
            bus.sel_dog = 1'b0;
            bus.sel_mouse = 1'b0;
        end
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        repeat (8) tick4();
    endtask

    task automatic restart(input logic [1:0] diff);
        bus.start = 1'b0;
        cyc();
        bus.difficulty = diff;
        bus.start = 1'b1;
        cyc();
    endtask

    initial begin
        bus.tick_4Hz = 1'b0;
        bus.tick_1Hz = 1'b0;
        bus.start = 1'b0;
        bus.difficulty = 2'd0;
        bus.sel_cat = 1'b0;
        bus.sel_dog = 1'b0;
        bus.sel_mouse = 1'b0;
        bus.go = 1'b0;
        cyc();
        cyc();
        check("rst_state", {6'd0, bus.game_state}, 8'd3);
        check("rst_timer", {bus.tens, bus.ones}, 8'h00);
        check("rst_pos", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'h0);
        check("rst_flags", {bus.cnt_canoe, bus.cat_crossing, bus.dog_crossing, bus.mouse_crossing, bus.canoe_crossing}, 8'h0);
        rst = 1'b0;
        cyc();
        check("idle_hold", {6'd0, bus.game_state}, 8'd3);

        // start on medium
        bus.difficulty = 2'd1;
        bus.start = 1'b1;
        cyc();
        check("start_state", {6'd0, bus.game_state}, 8'd2);
        check("start_timer", {bus.tens, bus.ones}, 8'h40);
        repeat (3) tick1();
        check("timer_37", {bus.tens, bus.ones}, 8'h37);

        // cat crosses with full animation checks
        bus.sel_cat = 1'b1;
        cyc();
        bus.sel_cat = 1'b0;
        check("board_cat", {7'd0, bus.cat_crossing}, 8'd1);
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        check("depart", {3'd0, bus.canoe_crossing, bus.cnt_canoe}, 8'h10);
        for (int i = 1; i < 8; i++) begin
            tick4();
            check("anim_step", {2'd0, bus.cat_crossing, bus.canoe_crossing, bus.cnt_canoe}, 8'(8'h30 + i));
        end
        tick4();
        check("after_cat", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'b1001);
        check("after_cat_flags", {bus.cnt_canoe, bus.cat_crossing, bus.dog_crossing, bus.mouse_crossing, bus.canoe_crossing}, 8'h0);
        check("after_cat_gs", {6'd0, bus.game_state}, 8'd2);

        // remainder of the solution
        do_cross(0, 0, 0);
        check("back_empty", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'b1000);
        do_cross(0, 0, 1);
        do_cross(1, 0, 0);
        check("cat_back", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'b0010);
        check("cat_back_gs", {6'd0, bus.game_state}, 8'd2);
        do_cross(0, 1, 0);
        do_cross(0, 0, 0);
        do_cross(1, 0, 0);
        check("win_pos", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'b1111);
        check("win_gs", {6'd0, bus.game_state}, 8'd1);
        tick1();
        check("win_timer_frozen", {bus.tens, bus.ones}, 8'h37);
        bus.sel_cat = 1'b1;
        bus.go = 1'b1;
        cyc();
        bus.sel_cat = 1'b0;
        bus.go = 1'b0;
        check("win_terminal", {6'd0, bus.cat_crossing, bus.canoe_crossing}, 8'd0);

        // empty crossing strands all three on the left
        restart(2'd0);
        check("easy_timer", {bus.tens, bus.ones}, 8'h60);
        check("restart_clear", {4'd0, bus.cat_position, bus.dog_position, bus.mouse_position, bus.canoe_position}, 8'h0);
        do_cross(0, 0, 0);
        check("empty_canoe", {7'd0, bus.canoe_position}, 8'd1);
        check("empty_lose", {6'd0, bus.game_state}, 8'd0);
        tick1();
        check("lose_frozen", {bus.tens, bus.ones}, 8'h60);

        // mouse first leaves cat with dog
        restart(2'd1);
        do_cross(0, 0, 1);
        check("mouse_first_lose", {6'd0, bus.game_state}, 8'd0);

        // hard difficulty timeout and saturation
        restart(2'd2);
        check("hard_timer", {bus.tens, bus.ones}, 8'h20);
        tick1();
        check("borrow", {bus.tens, bus.ones}, 8'h19);
        repeat (18) tick1();
        check("timer_01", {bus.tens, bus.ones}, 8'h01);
        check("timer_01_gs", {6'd0, bus.game_state}, 8'd2);
        tick1();
        check("timer_00", {bus.tens, bus.ones}, 8'h00);
        check("timeout_lose", {6'd0, bus.game_state}, 8'd0);
        repeat (3) tick1();
        check("timer_sat", {bus.tens, bus.ones}, 8'h00);

        // difficulty 3 maps to the hard start time
        restart(2'd3);
        check("diff3_timer", {bus.tens, bus.ones}, 8'h20);

        // boarding priority, replace and toggle
        restart(2'd0);
        bus.sel_cat = 1'b1;
        bus.sel_dog = 1'b1;
        cyc();
        bus.sel_cat = 1'b0;
        bus.sel_dog = 1'b0;
        check("prio_cat", {5'd0, bus.cat_crossing, bus.dog_crossing, bus.mouse_crossing}, 8'b100);
        bus.sel_dog = 1'b1;
        cyc();
        bus.sel_dog = 1'b0;
        check("replace_dog", {5'd0, bus.cat_crossing, bus.dog_crossing, bus.mouse_crossing}, 8'b010);
        bus.sel_dog = 1'b1;
        cyc();
        bus.sel_dog = 1'b0;
        check("toggle_off", {5'd0, bus.cat_crossing, bus.dog_crossing, bus.mouse_crossing}, 8'b000);

        // sel with go: sel applies, departure waits for go still held
        bus.sel_cat = 1'b1;
        bus.go = 1'b1;
        cyc();
        bus.sel_cat = 1'b0;
        check("sel_go_first", {6'd0, bus.cat_crossing, bus.canoe_crossing}, 8'b10);
        cyc();
        bus.go = 1'b0;
        check("sel_go_depart", {6'd0, bus.cat_crossing, bus.canoe_crossing}, 8'b11);
        bus.sel_dog = 1'b1;
        cyc();
        bus.sel_dog = 1'b0;
        check("cross_ignore_sel", {7'd0, bus.dog_crossing}, 8'd0);
        repeat (8) tick4();
        check("cat_over_gs", {6'd0, bus.game_state}, 8'd2);
        bus.sel_mouse = 1'b1;
        cyc();
        bus.sel_mouse = 1'b0;
        check("far_bank_ignored", {7'd0, bus.mouse_crossing}, 8'd0);

        // drop start mid-crossing
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        repeat (3) tick4();
        check("mid_cross_cnt", {4'd0, bus.cnt_canoe}, 8'd3);
        bus.start = 1'b0;
        cyc();
        check("stop_idle", {6'd0, bus.game_state}, 8'd3);
        check("stop_hold", {3'd0, bus.canoe_crossing, bus.cnt_canoe}, 8'h13);
        tick4();
        check("idle_no_anim", {4'd0, bus.cnt_canoe}, 8'd3);

        // async reset mid-crossing
        restart(2'd0);
        do_cross(1, 0, 0);
        bus.go = 1'b1;
        cyc();
        bus.go = 1'b0;
        tick4();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gs", {6'd0, bus.game_state}, 8'd3);
        check("async_rst_pos", {3'd0, bus.cat_position, bus.canoe_position, bus.canoe_crossing, bus.cnt_canoe[1:0]}, 8'h0);
        check("async_rst_timer", {bus.tens, bus.ones}, 8'h00);
        cyc();
        rst = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
